// File: rtl/mips_disasm_pkg.sv
// Shared constants, token/line types and text helpers for the MIPS disassembler.
// Build option: DASM_PC_PREFIX_EN prefixes every line with the pc.
package mips_disasm_pkg;

    localparam int LINE_CHARS = 64;
    localparam int TOK_CHARS  = 16;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] F_SLL     = 6'h00;
    localparam logic [5:0] F_SRL     = 6'h02;
    localparam logic [5:0] F_SRA     = 6'h03;
    localparam logic [5:0] F_SLLV    = 6'h04;
    localparam logic [5:0] F_SRLV    = 6'h06;
    localparam logic [5:0] F_SRAV    = 6'h07;
    localparam logic [5:0] F_JR      = 6'h08;
    localparam logic [5:0] F_JALR    = 6'h09;
    localparam logic [5:0] F_SYSCALL = 6'h0c;
    localparam logic [5:0] F_MFHI    = 6'h10;
    localparam logic [5:0] F_MTHI    = 6'h11;
    localparam logic [5:0] F_MFLO    = 6'h12;
    localparam logic [5:0] F_MTLO    = 6'h13;
    localparam logic [5:0] F_MULT    = 6'h18;
    localparam logic [5:0] F_MULTU   = 6'h19;
    localparam logic [5:0] F_DIV     = 6'h1a;
    localparam logic [5:0] F_DIVU    = 6'h1b;
    localparam logic [5:0] F_ADD     = 6'h20;
    localparam logic [5:0] F_ADDU    = 6'h21;
    localparam logic [5:0] F_SUB     = 6'h22;
    localparam logic [5:0] F_SUBU    = 6'h23;
    localparam logic [5:0] F_AND     = 6'h24;
    localparam logic [5:0] F_OR      = 6'h25;
    localparam logic [5:0] F_XOR     = 6'h26;
    localparam logic [5:0] F_NOR     = 6'h27;
    localparam logic [5:0] F_SLT     = 6'h2a;
    localparam logic [5:0] F_SLTU    = 6'h2b;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;
    localparam logic [4:0] RS_MFC0 = 5'd0;
    localparam logic [4:0] RS_MTC0 = 5'd4;

    localparam logic [31:0] ERET_WORD = 32'h42000018;

    localparam logic [31:0] ABI_NAMES [32] = '{
        "zero", "at", "v0", "v1", "a0", "a1", "a2", "a3",
        "t0", "t1", "t2", "t3", "t4", "t5", "t6", "t7",
        "s0", "s1", "s2", "s3", "s4", "s5", "s6", "s7",
        "t8", "t9", "k0", "k1", "gp", "sp", "fp", "ra"
    };

    // Operand layout selected by the decoder.
    typedef enum logic [3:0] {
        K_NONE, K_R3, K_RVS, K_SHI, K_RS, K_RD, K_RSRT, K_JALR,
        K_IS, K_IU, K_LUI, K_MEM, K_BR2, K_BR1, K_J, K_C0
    } kind_e;

    // Tokens are right-justified: last character in the low byte.
    typedef struct packed {
        logic [8*TOK_CHARS-1:0] s;
        logic [4:0]             len;
    } tok_t;

    // Lines are left-justified: first character in the high byte.
    typedef struct packed {
        logic [8*LINE_CHARS-1:0] txt;
        logic [6:0]              len;
    } line_t;

    function automatic tok_t lit(input logic [8*TOK_CHARS-1:0] s);
        tok_t t;
        t.s   = s;
        t.len = '0;
        for (int i = 0; i < TOK_CHARS; i++)
            if (s[8*i +: 8] != 8'h00) t.len = 5'(i + 1);
        return t;
    endfunction

    function automatic tok_t cat(input tok_t a, input tok_t b);
        tok_t t;
        t.s   = (a.s << (8 * int'(b.len))) | b.s;
        t.len = a.len + b.len;
        return t;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    function automatic tok_t hex_tok(input logic [31:0] v,
                                     input int ndig,
                                     input logic pfx);
        tok_t t;
        t.s   = '0;
        t.len = 5'(ndig);
        for (int i = 0; i < 8; i++)
            if (i < ndig) t.s[8*i +: 8] = hex_char(v[4*i +: 4]);
        if (pfx) t = cat(lit("0x"), t);
        return t;
    endfunction

    function automatic tok_t dec_tok(input logic [15:0] v);
        tok_t t;
        logic [15:0] r;
        logic [3:0]  d;
        t.s   = '0;
        t.len = 5'd1;
        r     = v;
        for (int i = 0; i < 5; i++) begin
            d = 4'(r % 16'd10);
            t.s[8*i +: 8] = 8'h30 + {4'h0, d};
            if (d != 4'd0) t.len = 5'(i + 1);
            r = r / 16'd10;
        end
        for (int i = 0; i < 5; i++)
            if (i >= int'(t.len)) t.s[8*i +: 8] = 8'h00;
        return t;
    endfunction

    // Negation of 0x8000 wraps to 0x8000, which reads as 32768 unsigned.
    function automatic tok_t sdec_tok(input logic [15:0] v);
        logic [15:0] mag;
        mag = -v;
        return v[15] ? cat(lit("-"), dec_tok(mag)) : dec_tok(v);
    endfunction

    function automatic tok_t reg_tok(input logic [4:0] idx, input logic abi);
        tok_t n;
        n = abi ? lit({96'h0, ABI_NAMES[idx]}) : dec_tok({11'h0, idx});
        return cat(lit("$"), n);
    endfunction

    function automatic line_t blank_line();
        line_t l;
        l.txt = {LINE_CHARS{8'h20}};
        l.len = '0;
        return l;
    endfunction

    function automatic line_t append(input line_t l, input tok_t t);
        line_t r;
        r = l;
        for (int i = 0; i < TOK_CHARS; i++)
            if (i < int'(t.len) && int'(r.len) < LINE_CHARS) begin
                r.txt[8*(LINE_CHARS-1-int'(r.len)) +: 8] =
                    t.s[8*(int'(t.len)-1-i) +: 8];
                r.len = r.len + 7'd1;
            end
        return r;
    endfunction

endpackage

// File: rtl/mips_disasm_fmt.sv
// Combinational decode of one instruction into left-justified ASCII text.
// Build option: DASM_PC_PREFIX_EN prepends "pppppppp: ".
module mips_disasm_fmt
    import mips_disasm_pkg::*;
#(
    parameter int ASM_CHARS = 48
) (
    input  logic [31:0]            pc,
    input  logic [31:0]            instr,
    input  logic                   imm_as_dec,
    input  logic                   reg_name,
    output logic [8*ASM_CHARS-1:0] text
);

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign j_tgt    = {pc_plus4[31:28], instr[25:0], 2'b00};

    logic is_nop;
    logic is_eret;
    logic is_special;
    logic is_regimm;
    logic is_cop0;

    assign is_nop     = (instr == 32'h0);
    assign is_eret    = (instr == ERET_WORD);
    assign is_special = (op == OP_SPECIAL) && !is_nop;
    assign is_regimm  = (op == OP_REGIMM);
    assign is_cop0    = (op == OP_COP0) && !is_eret;

    tok_t  mn;
    kind_e kind;

    always_comb begin
        mn   = lit("unknown");
        kind = K_NONE;
        unique case (1'b1)
            is_nop:  mn = lit("nop");
            is_eret: mn = lit("eret");
            is_special: begin
                case (funct)
                    F_ADD:     begin mn = lit("add");     kind = K_R3;   end
                    F_ADDU:    begin mn = lit("addu");    kind = K_R3;   end
                    F_SUB:     begin mn = lit("sub");     kind = K_R3;   end
                    F_SUBU:    begin mn = lit("subu");    kind = K_R3;   end
                    F_AND:     begin mn = lit("and");     kind = K_R3;   end
                    F_OR:      begin mn = lit("or");      kind = K_R3;   end
                    F_XOR:     begin mn = lit("xor");     kind = K_R3;   end
                    F_NOR:     begin mn = lit("nor");     kind = K_R3;   end
                    F_SLT:     begin mn = lit("slt");     kind = K_R3;   end
                    F_SLTU:    begin mn = lit("sltu");    kind = K_R3;   end
                    F_SLLV:    begin mn = lit("sllv");    kind = K_RVS;  end
                    F_SRLV:    begin mn = lit("srlv");    kind = K_RVS;  end
                    F_SRAV:    begin mn = lit("srav");    kind = K_RVS;  end
                    F_SLL:     begin mn = lit("sll");     kind = K_SHI;  end
                    F_SRL:     begin mn = lit("srl");     kind = K_SHI;  end
                    F_SRA:     begin mn = lit("sra");     kind = K_SHI;  end
                    F_JR:      begin mn = lit("jr");      kind = K_RS;   end
                    F_JALR:    begin mn = lit("jalr");    kind = K_JALR; end
                    F_MULT:    begin mn = lit("mult");    kind = K_RSRT; end
                    F_MULTU:   begin mn = lit("multu");   kind = K_RSRT; end
                    F_DIV:     begin mn = lit("div");     kind = K_RSRT; end
                    F_DIVU:    begin mn = lit("divu");    kind = K_RSRT; end
                    F_MFHI:    begin mn = lit("mfhi");    kind = K_RD;   end
                    F_MFLO:    begin mn = lit("mflo");    kind = K_RD;   end
                    F_MTHI:    begin mn = lit("mthi");    kind = K_RS;   end
                    F_MTLO:    begin mn = lit("mtlo");    kind = K_RS;   end
                    F_SYSCALL: mn = lit("syscall");
                    default:   mn = lit("unknown");
                endcase
            end
            is_regimm: begin
                case (rt)
                    RT_BLTZ: begin mn = lit("bltz"); kind = K_BR1; end
                    RT_BGEZ: begin mn = lit("bgez"); kind = K_BR1; end
                    default: mn = lit("unknown");
                endcase
            end
            is_cop0: begin
                case (rs)
                    RS_MFC0: begin mn = lit("mfc0"); kind = K_C0; end
                    RS_MTC0: begin mn = lit("mtc0"); kind = K_C0; end
                    default: mn = lit("unknown");
                endcase
            end
            default: begin
                case (op)
                    OP_J:     begin mn = lit("j");     kind = K_J;   end
                    OP_JAL:   begin mn = lit("jal");   kind = K_J;   end
                    OP_BEQ:   begin mn = lit("beq");   kind = K_BR2; end
                    OP_BNE:   begin mn = lit("bne");   kind = K_BR2; end
                    OP_BLEZ:  begin mn = lit("blez");  kind = K_BR1; end
                    OP_BGTZ:  begin mn = lit("bgtz");  kind = K_BR1; end
                    OP_ADDI:  begin mn = lit("addi");  kind = K_IS;  end
                    OP_ADDIU: begin mn = lit("addiu"); kind = K_IS;  end
                    OP_SLTI:  begin mn = lit("slti");  kind = K_IS;  end
                    OP_SLTIU: begin mn = lit("sltiu"); kind = K_IS;  end
                    OP_ANDI:  begin mn = lit("andi");  kind = K_IU;  end
                    OP_ORI:   begin mn = lit("ori");   kind = K_IU;  end
                    OP_XORI:  begin mn = lit("xori");  kind = K_IU;  end
                    OP_LUI:   begin mn = lit("lui");   kind = K_LUI; end
                    OP_LB:    begin mn = lit("lb");    kind = K_MEM; end
                    OP_LH:    begin mn = lit("lh");    kind = K_MEM; end
                    OP_LW:    begin mn = lit("lw");    kind = K_MEM; end
                    OP_LBU:   begin mn = lit("lbu");   kind = K_MEM; end
                    OP_LHU:   begin mn = lit("lhu");   kind = K_MEM; end
                    OP_SB:    begin mn = lit("sb");    kind = K_MEM; end
                    OP_SH:    begin mn = lit("sh");    kind = K_MEM; end
                    OP_SW:    begin mn = lit("sw");    kind = K_MEM; end
                    default:  mn = lit("unknown");
                endcase
            end
        endcase
    end

    tok_t t_rs;
    tok_t t_rt;
    tok_t t_rd;
    tok_t t_simm;
    tok_t t_uimm;
    tok_t t_mem;
    tok_t t_imm_hex;

    assign t_rs      = reg_tok(rs, reg_name);
    assign t_rt      = reg_tok(rt, reg_name);
    assign t_rd      = reg_tok(rd, reg_name);
    assign t_imm_hex = hex_tok({16'h0, imm}, 4, 1'b1);
    assign t_simm    = imm_as_dec ? sdec_tok(imm) : t_imm_hex;
    assign t_uimm    = imm_as_dec ? dec_tok(imm) : t_imm_hex;
    assign t_mem     = cat(cat(t_simm, lit("(")), cat(t_rs, lit(")")));

    tok_t       o0;
    tok_t       o1;
    tok_t       o2;
    logic [1:0] nops;

    always_comb begin
        o0   = '0;
        o1   = '0;
        o2   = '0;
        nops = 2'd0;
        case (kind)
            K_R3:   begin o0 = t_rd; o1 = t_rs; o2 = t_rt; nops = 2'd3; end
            K_RVS:  begin o0 = t_rd; o1 = t_rt; o2 = t_rs; nops = 2'd3; end
            K_SHI: begin
                o0   = t_rd;
                o1   = t_rt;
                o2   = dec_tok({11'h0, shamt});
                nops = 2'd3;
            end
            K_RS:   begin o0 = t_rs; nops = 2'd1; end
            K_RD:   begin o0 = t_rd; nops = 2'd1; end
            K_RSRT: begin o0 = t_rs; o1 = t_rt; nops = 2'd2; end
            K_JALR: begin o0 = t_rd; o1 = t_rs; nops = 2'd2; end
            K_IS:   begin o0 = t_rt; o1 = t_rs; o2 = t_simm; nops = 2'd3; end
            K_IU:   begin o0 = t_rt; o1 = t_rs; o2 = t_uimm; nops = 2'd3; end
            K_LUI:  begin o0 = t_rt; o1 = t_uimm; nops = 2'd2; end
            K_MEM:  begin o0 = t_rt; o1 = t_mem; nops = 2'd2; end
            K_BR2: begin
                o0   = t_rs;
                o1   = t_rt;
                o2   = hex_tok(br_tgt, 8, 1'b1);
                nops = 2'd3;
            end
            K_BR1: begin
                o0   = t_rs;
                o1   = hex_tok(br_tgt, 8, 1'b1);
                nops = 2'd2;
            end
            K_J:    begin o0 = hex_tok(j_tgt, 8, 1'b1); nops = 2'd1; end
            // CP0 register index is always numeric.
            K_C0: begin
                o0   = t_rt;
                o1   = cat(lit("$"), dec_tok({11'h0, rd}));
                nops = 2'd2;
            end
            default: nops = 2'd0;
        endcase
    end

    line_t line;

    always_comb begin
        line = blank_line();
`ifdef DASM_PC_PREFIX_EN
        line = append(line, hex_tok(pc, 8, 1'b0));
        line = append(line, lit(": "));
`endif
        line = append(line, mn);
        if (nops >= 2'd1) line = append(append(line, lit(" ")), o0);
        if (nops >= 2'd2) line = append(append(line, lit(", ")), o1);
        if (nops >= 2'd3) line = append(append(line, lit(", ")), o2);
    end

    if (ASM_CHARS <= LINE_CHARS) begin : g_trunc
        assign text = line.txt[8*LINE_CHARS-1 -: 8*ASM_CHARS];
    end else begin : g_pad
        assign text = {line.txt, {(ASM_CHARS-LINE_CHARS){8'h20}}};
    end

endmodule

// File: rtl/mips_disasm.sv
// Registered MIPS disassembly string for trace/waveform visibility.
// Build option: DASM_PC_PREFIX_EN adds a pc prefix to the text.
module mips_disasm
    import mips_disasm_pkg::*;
#(
    parameter int ASM_CHARS = 48
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            pc,
    input  logic [31:0]            instr,
    input  logic                   imm_as_dec,
    input  logic                   reg_name,
    output logic [8*ASM_CHARS-1:0] asm
);

    logic [8*ASM_CHARS-1:0] text;

    mips_disasm_fmt #(
        .ASM_CHARS(ASM_CHARS)
    ) u_fmt (
        .pc        (pc),
        .instr     (instr),
        .imm_as_dec(imm_as_dec),
        .reg_name  (reg_name),
        .text      (text)
    );

    always_ff @(posedge clk) begin
        if (reset) asm <= {ASM_CHARS{8'h20}};
        else       asm <= text;
    end

endmodule

// File: tb/tb_mips_disasm.sv
// Directed vector bench for mips_disasm, with reset and latency sequences.
// Expectations follow the pc prefix when built with DASM_PC_PREFIX_EN.
module tb_mips_disasm;

    localparam int N = 48;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    pc;
    logic [31:0]    instr;
    logic           imm_as_dec;
    logic           reg_name;
    logic [8*N-1:0] asm;

    int n_cmp  = 0;
    int n_fail = 0;

    mips_disasm #(.ASM_CHARS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .imm_as_dec(imm_as_dec),
        .reg_name  (reg_name),
        .asm       (asm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        dec;
        logic        abi;
        string       txt;
    } vec_t;

    vec_t vecs [22];

    function automatic logic [8*N-1:0] to_asm(input string s);
        logic [8*N-1:0] r;
        r = {N{8'h20}};
        for (int i = 0; i < s.len() && i < N; i++)
            r[8*(N-1-i) +: 8] = s[i];
        return r;
    endfunction

    function automatic string with_pc(input logic [31:0] p, input string s);
`ifdef DASM_PC_PREFIX_EN
        return $sformatf("%08h: %s", p, s);
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [8*N-1:0] exp);
        n_cmp++;
        if (asm !== exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, asm, exp);
        end
    endtask

    task automatic apply(input logic [31:0] p, input logic [31:0] i,
                         input logic d, input logic a);
        pc         = p;
        instr      = i;
        imm_as_dec = d;
        reg_name   = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h0, 32'h3c010001, 1'b1, 1'b0, "lui $1, 1"};
        vecs[1]  = '{32'h0, 32'h3c010001, 1'b0, 1'b0, "lui $1, 0x0001"};
        vecs[2]  = '{32'h0, 32'h2008ffff, 1'b1, 1'b1, "addi $t0, $zero, -1"};
        vecs[3]  = '{32'h0, 32'h2008ffff, 1'b0, 1'b1, "addi $t0, $zero, 0xffff"};
        vecs[4]  = '{32'h3000, 32'h1000ffff, 1'b1, 1'b0, "beq $0, $0, 0x00003000"};
        vecs[5]  = '{32'h3004, 32'h0c000c00, 1'b1, 1'b0, "jal 0x00003000"};
        vecs[6]  = '{32'h0, 32'h42000018, 1'b1, 1'b1, "eret"};
        vecs[7]  = '{32'h0, 32'h8fa40008, 1'b1, 1'b1, "lw $a0, 8($sp)"};
        vecs[8]  = '{32'h0, 32'hfc000000, 1'b1, 1'b1, "unknown"};
        vecs[9]  = '{32'h0, 32'h01095020, 1'b1, 1'b1, "add $t2, $t0, $t1"};
        vecs[10] = '{32'h0, 32'h00831004, 1'b1, 1'b0, "sllv $2, $3, $4"};
        vecs[11] = '{32'h0, 32'h00020fc0, 1'b0, 1'b0, "sll $1, $2, 31"};
        vecs[12] = '{32'h0, 32'h3409ffff, 1'b1, 1'b1, "ori $t1, $zero, 65535"};
        vecs[13] = '{32'h0, 32'h27bd8000, 1'b1, 1'b1, "addiu $sp, $sp, -32768"};
        vecs[14] = '{32'h00400000, 32'h04600001, 1'b1, 1'b0, "bltz $3, 0x00400008"};
        vecs[15] = '{32'h0, 32'h401a6000, 1'b1, 1'b1, "mfc0 $k0, $12"};
        vecs[16] = '{32'h0, 32'h03e00008, 1'b1, 1'b1, "jr $ra"};
        vecs[17] = '{32'h0, 32'h00001012, 1'b1, 1'b1, "mflo $v0"};
        vecs[18] = '{32'h0, 32'hafa8fffc, 1'b0, 1'b1, "sw $t0, 0xfffc($sp)"};
        vecs[19] = '{32'h0, 32'h0000000c, 1'b1, 1'b1, "syscall"};
        vecs[20] = '{32'h3000, 32'h00000000, 1'b1, 1'b1, "nop"};
        vecs[21] = '{32'h0, 32'h94000000, 1'b1, 1'b0, "lhu $0, 0($0)"};

        reset      = 1'b1;
        pc         = 32'h3000;
        instr      = 32'h0;
        imm_as_dec = 1'b1;
        reg_name   = 1'b0;

        @(posedge clk); #1;
        check("reset_c1", {N{8'h20}});
        @(posedge clk); #1;
        check("reset_c2", {N{8'h20}});

        reset = 1'b0;
        @(posedge clk); #1;
        check("nop_after_reset", to_asm(with_pc(32'h3000, "nop")));

        apply(32'h0, 32'h3c010001, 1'b1, 1'b0);
        check("lui_dec", to_asm(with_pc(32'h0, "lui $1, 1")));
        imm_as_dec = 1'b0;
        @(negedge clk);
        check("latency_hold", to_asm(with_pc(32'h0, "lui $1, 1")));
        @(posedge clk); #1;
        check("latency_update", to_asm(with_pc(32'h0, "lui $1, 0x0001")));

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i].pc, vecs[i].instr, vecs[i].dec, vecs[i].abi);
            check($sformatf("vec%0d", i),
                  to_asm(with_pc(vecs[i].pc, vecs[i].txt)));
        end

        reset = 1'b1;
        apply(32'h0, 32'h8fa40008, 1'b1, 1'b1);
        check("reset_priority", {N{8'h20}});
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_lw", to_asm(with_pc(32'h0, "lw $a0, 8($sp)")));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_disasm.md
Name: mips_disasm

Overview:
- Simulation/debug helper that turns one 32-bit MIPS instruction and its PC into a space-padded ASCII assembly string.
- Sits beside the fetch stage (IFU). It is driven by the fetched pc/instr, for waveform and trace visibility.
- It has no effect on datapath state. The output is registered once per clock.

Parameters:
- ASM_CHARS, 48: output string length in characters. The output is 8*ASM_CHARS bits wide.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- pc, input, 32: address of instr. Used for branch and jump target computation.
- instr, input, 32: instruction word to disassemble.
- imm_as_dec, input, 1: 1 = immediates printed in decimal; 0 = immediates printed in hex.
- reg_name, input, 1: 1 = ABI register names ($zero, $at, $v0..$ra); 0 = numeric names ($0..$31).
- asm, output, 8*ASM_CHARS: ASCII text. The first character is in the MSBs (Verilog string packing). Left-justified and padded with 0x20.

Behaviour:
- Text is decoded combinationally from instr/pc/imm_as_dec/reg_name. asm captures it on every posedge clk, so latency is exactly 1 cycle. There is no enable and no handshake.
- Reset: asm = all spaces (every byte 0x20). Reset has priority over capture.
- Output length: text longer than ASM_CHARS is truncated on the right. No partial multi-byte effects.
- Format: mnemonic in lowercase, one space, then operands separated by ", ".
- R-type arithmetic/logic ops:
  - Mnemonics: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sllv, srlv, srav.
  - Format: "op rd, rs, rt". The variable shifts use "op rd, rt, rs".
- sll/srl/sra: "op rd, rt, shamt", with shamt always decimal 0..31.
- instr == 0x00000000 prints "nop". This takes priority over sll.
- jr: "jr rs". jalr: "jalr rd, rs".
- Multiply/divide group:
  - mult/multu/div/divu: "op rs, rt".
  - mfhi/mflo: "op rd".
  - mthi/mtlo: "op rs".
- syscall: "syscall". eret (0x42000018): "eret".
- mfc0/mtc0: "op rt, $rd". The CP0 register is always numeric, e.g. "$12".
- I-type immediate ops:
  - Signed immediates: addi, addiu, slti, sltiu. Printed as signed decimal (e.g. -1) or hex.
  - Zero-extended immediates: andi, ori, xori. Printed as unsigned decimal 0..65535 or hex.
  - Format: "op rt, rs, imm".
  - lui: "lui rt, imm", unsigned.
- Hex immediate form: "0x" followed by 4 lowercase digits of the raw 16-bit field.
- Loads/stores: lw, lh, lhu, lb, lbu, sw, sh, sb. Format: "op rt, imm(rs)" with a signed immediate.
- Branches:
  - beq/bne: "op rs, rt, T".
  - blez/bgtz/bltz/bgez: "op rs, T".
  - bltz/bgez are decoded from the REGIMM rt field.
  - T = pc + 4 + (sign_ext(imm) << 2), always printed as "0x" + 8 lowercase hex digits, regardless of imm_as_dec.
- j/jal: "op T", with T = {pc_plus4[31:28], index, 2'b00}, in 8-digit hex.
- Any other encoding prints "unknown".
- Decimal conversion is exact for the full 16-bit range. Leading zeros are suppressed. "0" prints as "0".

Optional Feature:
- DASM_PC_PREFIX_EN defined: the text is prefixed with the pc as 8 lowercase hex digits followed by ": ".
  - Example: "00003000: nop".
  - Truncation rules apply to the combined string.
- DASM_PC_PREFIX_EN undefined: no prefix is added. pc is used only for branch and jump targets.

Decomposition:
- Shared package (mips_disasm_pkg):
  - opcode/funct/rt constants.
  - 32-entry register ABI name table.
  - Helper functions: hex digit to ASCII, 16-bit-to-decimal string, string append.
- One sub-module, mips_disasm_fmt (combinational decode/format). The top module only adds the output register and reset.

Test Plan:
- reset=1 for 2 cycles, instr=0x00000000 -> asm all 0x20. After release, one cycle later -> "nop".
- instr=0x3c010001, reg_name=0:
  - imm_as_dec=1 -> "lui $1, 1".
  - imm_as_dec=0 -> "lui $1, 0x0001".
  - Each result appears 1 clock after the input change.
- instr=0x2008ffff, reg_name=1, imm_as_dec=1 -> "addi $t0, $zero, -1". With imm_as_dec=0 -> "addi $t0, $zero, 0xffff".
- pc=0x00003000, instr=0x1000ffff -> "beq $0, $0, 0x00003000".
- pc=0x00003004, instr=0x0c000c00 -> "jal 0x00003000".
- Mixed encodings:
  - instr=0x42000018 -> "eret".
  - instr=0x8fa40008, reg_name=1 -> "lw $a0, 8($sp)".
  - instr=0xfc000000 -> "unknown".
- Macro variant: DASM_PC_PREFIX_EN build with pc=0x00003000, instr=0 -> "00003000: nop".
